instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Boot-time program loader. Accepts decoded instruction fields over a valid/ready stream,
//  encodes each one into a 32-bit MIPS machine word and writes it to instruction memory
//  at consecutive word addresses. It is the encode-side counterpart of the control path's
//  opcode/funct decode. While loading it holds the single-cycle core in reset/hold.
// PARAMETERS
//  ADDR_W     6   instruction-memory word-address width (depth = 2**ADDR_W)
//  BASE_ADDR  0   first word address written after Start
// PORTS
//  CLK         in   1       clock; all state updates on rising edge
//  RST         in   1       asynchronous reset, active-high
//  Start       in   1       pulse: begin a load session (honoured only in IDLE/ERROR)
//  In_Valid    in   1       instruction fields valid
//  In_Ready    out  1       loader accepts fields this cycle
//  In_Kind     in   3       0=RTYPE 1=LW 2=SW 3=BEQ 4=ADDI 5=J 6=END 7=reserved
//  Rs,Rt,Rd    in   5 each  register fields
//  Funct       in   6       RTYPE function (add 100000, sub 100010, and 100100, or 100101, slt 101010)
//  Imm         in   16      immediate / branch offset
//  Target      in   26      jump target field
//  IMem_WE     out  1       instruction-memory write strobe
//  IMem_Addr   out  ADDR_W  word address for write
//  IMem_WData  out  32      encoded instruction
//  CPU_Hold    out  1       hold processor (PC/regfile writes blocked) while 1
//  Done        out  1       one-cycle pulse: END accepted, program complete
//  Error       out  1       sticky: illegal Kind/Funct or memory overflow
// BEHAVIOUR
//  Reset: state=IDLE, addr=BASE_ADDR; In_Ready, IMem_WE, IMem_WData, CPU_Hold, Done, Error = 0.
//  States IDLE, LOAD, DONE, ERROR.
//   IDLE : Start -> LOAD, addr<=BASE_ADDR, CPU_Hold<=1.
//   LOAD : In_Ready=1 (combinational on state). Transfer = In_Valid & In_Ready.
//          legal non-END transfer -> next cycle IMem_WE=1, IMem_Addr=addr, IMem_WData=encoding;
//          addr<=addr+1. Latency exactly 1 cycle; back-to-back transfers give back-to-back writes.
//          END transfer -> DONE, no write. Kind 7 or unlisted Funct -> ERROR, no write.
//          Transfer while addr already wrapped past last word (BASE_ADDR+count==2**ADDR_W) -> ERROR.
//          Start while in LOAD is ignored.
//   DONE : Done=1 for this one cycle, CPU_Hold<=0, -> IDLE.
//   ERROR: Error=1, CPU_Hold=1, In_Ready=0; Start clears Error and restarts LOAD at BASE_ADDR.
//  Encoding (op,rs,rt,rd,shamt=0,funct / op,rs,rt,imm / op,target):
//   RTYPE 000000 | LW 100011 | SW 101011 | BEQ 000100 | ADDI 001000 | J 000010.
//   I-type uses Rs,Rt,Imm; J uses Target; unused inputs ignored.
//  IMem_WE is 1 only in the cycle following a legal transfer; IMem_WData/IMem_Addr hold last value otherwise.
//  Reset asserted mid-LOAD aborts immediately: all outputs to reset values, partial program left in memory.
// STRUCTURE
//  Shared package: In_Kind codes, opcode constants, legal Funct constants, state encoding.
//  One sub-module: mips_instr_encoder (combinational fields -> {word, illegal}); loader FSM,
//  address counter and output registers live in the top.
// TESTING
//  1 Start, RTYPE rs=9 rt=10 rd=8 funct=100000 -> next cycle WE=1, Addr=0, WData=0x012A4020.
//  2 Back-to-back LW rs=0 rt=8 imm=4; SW rs=0 rt=9 imm=8; BEQ rs=8 rt=9 imm=FFFE; ADDI rs=0 rt=8 imm=5;
//    J target=0x10 -> WData 0x8C080004,0xAC090008,0x1109FFFE,0x20080005,0x08000010 at Addr 0..4 on consecutive cycles.
//  3 END after 2 -> no write, Done pulse 1 cycle, CPU_Hold falls same cycle, state IDLE, In_Ready=0.
//  4 RTYPE funct=000111 -> no WE, Error=1, CPU_Hold=1; then Start -> Error=0, next write at Addr 0.
//  5 ADDR_W=2: 4 legal writes Addr 0..3, fifth transfer -> Error=1, no write; In_Valid while In_Ready=0 ignored.
//  6 Assert RST between transfers mid-LOAD -> all outputs 0 asynchronously; Start restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the boot-time program loader:
// field kinds, MIPS opcodes, legal R-type functs, FSM states.
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_LW    = 3'd1,
    K_SW    = 3'd2,
    K_BEQ   = 3'd3,
    K_ADDI  = 3'd4,
    K_J     = 3'd5,
    K_END   = 3'd6,
    K_RSVD  = 3'd7
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  function automatic logic funct_legal(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_encoder.sv
// Combinational MIPS encoder: decoded fields -> 32-bit word
// plus an illegal flag for reserved kinds or unknown functs.
module mips_instr_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (kind == K_RTYPE): begin
        word    = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
        illegal = !funct_legal(funct);
      end
      (kind == K_LW):   word = {OP_LW, rs, rt, imm};
      (kind == K_SW):   word = {OP_SW, rs, rt, imm};
      (kind == K_BEQ):  word = {OP_BEQ, rs, rt, imm};
      (kind == K_ADDI): word = {OP_ADDI, rs, rt, imm};
      (kind == K_J):    word = {OP_J, target};
      (kind == K_END):  word = '0;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot loader: streams decoded fields into instruction memory
// as encoded MIPS words while holding the core.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [2:0]        In_Kind,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [5:0]        Funct,
  input  logic [15:0]       Imm,
  input  logic [25:0]       Target,
  output logic              IMem_WE,
  output logic [ADDR_W-1:0] IMem_Addr,
  output logic [31:0]       IMem_WData,
  output logic              CPU_Hold,
  output logic              Done,
  output logic              Error
);

  // Extra MSB on the counter marks "memory full" after wrap.
  localparam logic [ADDR_W:0] BASE = BASE_ADDR[ADDR_W:0];

  state_e          state;
  logic [ADDR_W:0] addr;
  logic [31:0]     word;
  logic            illegal;
  logic            xfer;
  logic            is_end;
  logic            full;

  mips_instr_encoder u_enc (
    .kind    (In_Kind),
    .rs      (Rs),
    .rt      (Rt),
    .rd      (Rd),
    .funct   (Funct),
    .imm     (Imm),
    .target  (Target),
    .word    (word),
    .illegal (illegal)
  );

  assign In_Ready = (state == S_LOAD);
  assign xfer     = In_Valid & In_Ready;
  assign is_end   = (In_Kind == K_END);
  assign full     = addr[ADDR_W];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      addr       <= BASE;
      IMem_WE    <= 1'b0;
      IMem_Addr  <= BASE[ADDR_W-1:0];
      IMem_WData <= '0;
      CPU_Hold   <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      IMem_WE <= 1'b0;
      Done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            state    <= S_LOAD;
            addr     <= BASE;
            CPU_Hold <= 1'b1;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            if (is_end) begin
              state    <= S_DONE;
              Done     <= 1'b1;
              CPU_Hold <= 1'b0;
            end else if (illegal || full) begin
              state <= S_ERROR;
              Error <= 1'b1;
            end else begin
              IMem_WE    <= 1'b1;
              IMem_Addr  <= addr[ADDR_W-1:0];
              IMem_WData <= word;
              addr       <= addr + 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERROR: begin
          if (Start) begin
            state <= S_LOAD;
            addr  <= BASE;
            Error <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench: two loaders (64-word and 4-word memories) on one stimulus
// stream, checked against a behavioural model every cycle.
module tb_instr_encoder_loader;

  localparam int MI = 0;
  localparam int ML = 1;
  localparam int MD = 2;
  localparam int ME = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic        In_Valid = 1'b0;
  logic [2:0]  In_Kind = '0;
  logic [4:0]  Rs = '0;
  logic [4:0]  Rt = '0;
  logic [4:0]  Rd = '0;
  logic [5:0]  Funct = '0;
  logic [15:0] Imm = '0;
  logic [25:0] Target = '0;

  logic        rdy  [2];
  logic        we   [2];
  logic        hold [2];
  logic        done [2];
  logic        err  [2];
  logic [31:0] wd   [2];
  logic [5:0]  a6;
  logic [1:0]  a2;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_mode [2];
  int          m_cnt  [2];
  int          m_we   [2];
  int          m_addr [2];
  int          m_hold [2];
  int          m_done [2];
  int          m_err  [2];
  logic [31:0] m_wd   [2];
  int          depth  [2] = '{64, 4};

  always #5 CLK = ~CLK;

  instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) d6 (
    .CLK(CLK), .RST(RST), .Start(Start), .In_Valid(In_Valid),
    .In_Ready(rdy[0]), .In_Kind(In_Kind), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Funct(Funct), .Imm(Imm), .Target(Target), .IMem_WE(we[0]),
    .IMem_Addr(a6), .IMem_WData(wd[0]), .CPU_Hold(hold[0]),
    .Done(done[0]), .Error(err[0])
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) d2 (
    .CLK(CLK), .RST(RST), .Start(Start), .In_Valid(In_Valid),
    .In_Ready(rdy[1]), .In_Kind(In_Kind), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Funct(Funct), .Imm(Imm), .Target(Target), .IMem_WE(we[1]),
    .IMem_Addr(a2), .IMem_WData(wd[1]), .CPU_Hold(hold[1]),
    .Done(done[1]), .Error(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_addr(input int i);
    return (i == 0) ? {26'd0, a6} : {30'd0, a2};
  endfunction

  function automatic bit funct_ok(input int unsigned f);
    int unsigned legal [5] = '{32, 34, 36, 37, 42};
    foreach (legal[k]) if (legal[k] == f) return 1'b1;
    return 1'b0;
  endfunction

  // Word value built arithmetically from field weights.
  function automatic logic [31:0] encode();
    int unsigned ops [6] = '{0, 35, 43, 4, 8, 2};
    int unsigned op, rs, rt, rd, fn, im, tg, w;
    op = ops[(In_Kind < 6) ? In_Kind : 0];
    rs = Rs; rt = Rt; rd = Rd; fn = Funct; im = Imm; tg = Target;
    if (In_Kind == 0)
      w = rs * 32'h0020_0000 + rt * 32'h0001_0000 + rd * 32'h0000_0800 + fn;
    else if (In_Kind == 5)
      w = op * 32'h0400_0000 + tg;
    else
      w = op * 32'h0400_0000 + rs * 32'h0020_0000 + rt * 32'h0001_0000 + im;
    return w;
  endfunction

  task automatic model_reset(input int i);
    m_mode[i] = MI; m_cnt[i] = 0; m_we[i] = 0; m_addr[i] = 0;
    m_hold[i] = 0; m_done[i] = 0; m_err[i] = 0; m_wd[i] = '0;
  endtask

  task automatic model_step(input int i);
    m_we[i] = 0;
    m_done[i] = 0;
    case (m_mode[i])
      MI: if (Start) begin
        m_mode[i] = ML; m_cnt[i] = 0; m_hold[i] = 1;
      end
      ML: if (In_Valid) begin
        if (In_Kind == 6) begin
          m_mode[i] = MD; m_done[i] = 1; m_hold[i] = 0;
        end else if (In_Kind == 7 || (In_Kind == 0 && !funct_ok(Funct)) ||
                     m_cnt[i] == depth[i]) begin
          m_mode[i] = ME; m_err[i] = 1;
        end else begin
          m_we[i] = 1; m_addr[i] = m_cnt[i]; m_wd[i] = encode();
          m_cnt[i]++;
        end
      end
      MD: m_mode[i] = MI;
      default: if (Start) begin
        m_mode[i] = ML; m_cnt[i] = 0; m_err[i] = 0;
      end
    endcase
  endtask

  task automatic check_outs(input int i);
    check($sformatf("we%0d", i),   32'(we[i]),   32'(m_we[i]));
    check($sformatf("addr%0d", i), dut_addr(i),  32'(m_addr[i]));
    check($sformatf("wdata%0d", i), wd[i],       m_wd[i]);
    check($sformatf("hold%0d", i), 32'(hold[i]), 32'(m_hold[i]));
    check($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
    check($sformatf("error%0d", i), 32'(err[i]), 32'(m_err[i]));
  endtask

  task automatic cyc();
    for (int i = 0; i < 2; i++)
      check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(m_mode[i] == ML));
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) check_outs(i);
    Start = 1'b0;
    In_Valid = 1'b0;
  endtask

  // Reset raised between edges: outputs must clear before any clock.
  task automatic do_reset();
    Start = 1'b0;
    In_Valid = 1'b0;
    RST = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd0);
      check_outs(i);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    cyc();
  endtask

  task automatic xfer(input int k, input int rs, input int rt, input int rd,
                      input int fn, input int im, input int tg);
    In_Kind = 3'(k); Rs = 5'(rs); Rt = 5'(rt); Rd = 5'(rd);
    Funct = 6'(fn); Imm = 16'(im); Target = 26'(tg);
    In_Valid = 1'b1;
    cyc();
  endtask

  initial begin
    logic [31:0] t2 [5];
    int r;
    t2 = '{32'h8C080004, 32'hAC090008, 32'h1109FFFE, 32'h20080005, 32'h08000010};

    #2;
    do_reset();

    // 1: single R-type add
    start_pulse();
    xfer(0, 9, 10, 8, 6'b100000, 0, 0);
    check("t1_word", wd[0], 32'h012A4020);
    check("t1_addr", dut_addr(0), 32'd0);

    // 2: back-to-back I/J types
    do_reset();
    start_pulse();
    xfer(1, 0, 8, 0, 0, 4, 0);
    check("t2_word0", wd[0], t2[0]);
    xfer(2, 0, 9, 0, 0, 8, 0);
    check("t2_word1", wd[0], t2[1]);
    xfer(3, 8, 9, 0, 0, 16'hFFFE, 0);
    check("t2_word2", wd[0], t2[2]);
    xfer(4, 0, 8, 0, 0, 5, 0);
    check("t2_word3", wd[0], t2[3]);
    xfer(5, 0, 0, 0, 0, 0, 26'h10);
    check("t2_word4", wd[0], t2[4]);
    check("t2_addr4", dut_addr(0), 32'd4);

    // 3: END completes the program
    xfer(6, 0, 0, 0, 0, 0, 0);
    check("t3_done", 32'(done[0]), 32'd1);
    check("t3_hold", 32'(hold[0]), 32'd0);
    cyc();
    check("t3_done_off", 32'(done[0]), 32'd0);

    // 4: illegal funct, recover with Start, Start ignored in LOAD
    start_pulse();
    xfer(0, 1, 2, 3, 6'b000111, 0, 0);
    check("t4_err", 32'(err[0]), 32'd1);
    check("t4_we", 32'(we[0]), 32'd0);
    start_pulse();
    check("t4_err_clr", 32'(err[0]), 32'd0);
    xfer(0, 1, 2, 3, 6'b101010, 0, 0);
    check("t4_addr0", dut_addr(0), 32'd0);
    start_pulse();
    xfer(0, 4, 5, 6, 6'b100010, 0, 0);
    check("t4_addr1", dut_addr(0), 32'd1);
    xfer(7, 0, 0, 0, 0, 0, 0);
    check("t4_rsvd", 32'(err[0]), 32'd1);

    // 5: small memory overflows on the fifth write
    start_pulse();
    for (int k = 0; k < 4; k++) xfer(4, k, k + 1, 0, 0, k * 3, 0);
    check("t5_last_addr", dut_addr(1), 32'd3);
    xfer(4, 7, 7, 0, 0, 99, 0);
    check("t5_err", 32'(err[1]), 32'd1);
    check("t5_we", 32'(we[1]), 32'd0);
    check("t5_big_ok", 32'(we[0]), 32'd1);
    xfer(1, 3, 3, 0, 0, 1, 0);
    check("t5_ignored", 32'(we[1]), 32'd0);
    xfer(6, 0, 0, 0, 0, 0, 0);
    cyc();

    // 6: reset mid-load, then restart
    start_pulse();
    xfer(1, 1, 1, 0, 0, 1, 0);
    xfer(2, 2, 2, 0, 0, 2, 0);
    do_reset();
    start_pulse();
    xfer(4, 3, 3, 0, 0, 7, 0);
    check("t6_addr", dut_addr(0), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        Start = ($urandom_range(0, 11) == 0);
        r = $urandom_range(0, 15);
        In_Kind = (r < 12) ? 3'(r % 6) : (r < 14) ? 3'd6 : (r == 14) ? 3'd7 : 3'd0;
        Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom);
        Imm = 16'($urandom); Target = 26'($urandom);
        case ($urandom_range(0, 4))
          0: Funct = 6'b100000;
          1: Funct = 6'b100010;
          2: Funct = 6'b100100;
          3: Funct = 6'b100101;
          default: Funct = 6'b101010;
        endcase
        if (r == 15) Funct = 6'($urandom);
        In_Valid = $urandom_range(0, 3) != 0;
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
